// File: rtl/jtframe_vtgen.sv
// Video timing generator: pixel/line counters with registered
// blank and sync flags decoded from the next counter values.
module jtframe_vtgen #(
  parameter int HCNT_END = 383,
  parameter int HB_START = 256,
  parameter int HB_END   = 0,
  parameter int HS_START = 288,
  parameter int HS_END   = 320,
  parameter int VCNT_END = 263,
  parameter int VB_START = 240,
  parameter int VB_END   = 16,
  parameter int VS_START = 250,
  parameter int VS_END   = 253
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       Hinit,
  output logic       Vinit,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS
);

  localparam bit BAD_RANGE =
    HCNT_END < 0 || HCNT_END > 511 ||
    VCNT_END < 0 || VCNT_END > 511 ||
    HB_START < 0 || HB_START > 511 ||
    HB_END   < 0 || HB_END   > 511 ||
    VB_START < 0 || VB_START > 511 ||
    VB_END   < 0 || VB_END   > 511 ||
    HS_START < 0 || HS_START > 511 ||
    HS_END   < 0 || HS_END   > 511 ||
    VS_START < 0 || VS_START > 511 ||
    VS_END   < 0 || VS_END   > 511;

  localparam bit BAD_ORDER =
    HB_END >= HB_START || HB_START > HCNT_END ||
    VB_END >= VB_START || VB_START > VCNT_END;

  // Illegal timing sets stop elaboration with a clear message
  if (BAD_RANGE || BAD_ORDER) begin : g_param_err
    $error("jtframe_vtgen: illegal timing parameters");
  end

  localparam logic [8:0] HCE = HCNT_END[8:0];
  localparam logic [8:0] HBS = HB_START[8:0];
  localparam logic [8:0] HBE = HB_END[8:0];
  localparam logic [8:0] HSS = HS_START[8:0];
  localparam logic [8:0] HSE = HS_END[8:0];
  localparam logic [8:0] VCE = VCNT_END[8:0];
  localparam logic [8:0] VBS = VB_START[8:0];
  localparam logic [8:0] VBE = VB_END[8:0];
  localparam logic [8:0] VSS = VS_START[8:0];
  localparam logic [8:0] VSE = VS_END[8:0];

  // Visible iff start<=x<end, since *B_END < *B_START
  localparam logic LHBL_RST = (HB_END == 0);
  localparam logic LVBL_RST = (VB_END == 0);

  function automatic logic in_rng(
    input logic [8:0] x,
    input logic [8:0] lo,
    input logic [8:0] hi
  );
    return (x >= lo) && (x < hi);
  endfunction

  logic [8:0] h_nxt;
  logic [8:0] v_nxt;
  logic       h_wrap;

  // Next counter values; V steps only on the last pixel of a line
  always_comb begin
    h_wrap = (H == HCE);
    h_nxt  = h_wrap ? 9'd0 : H + 9'd1;
    v_nxt  = V;
    if (h_wrap)
      v_nxt = (V == VCE) ? 9'd0 : V + 9'd1;
  end

  // Counters and flags share one register stage so they never skew
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      H     <= 9'd0;
      V     <= 9'd0;
      Hinit <= 1'b1;
      Vinit <= 1'b1;
      LHBL  <= LHBL_RST;
      LVBL  <= LVBL_RST;
      HS    <= 1'b0;
      VS    <= 1'b0;
    end else if (pxl_cen) begin
      H     <= h_nxt;
      V     <= v_nxt;
      Hinit <= (h_nxt == 9'd0);
      Vinit <= (h_nxt == 9'd0) && (v_nxt == 9'd0);
      LHBL  <= in_rng(h_nxt, HBE, HBS);
      LVBL  <= in_rng(v_nxt, VBE, VBS);
      HS    <= in_rng(h_nxt, HSS, HSE);
      VS    <= in_rng(v_nxt, VSS, VSE);
    end
  end

endmodule

// File: tb/tb_jtframe_vtgen.sv
// Bench for jtframe_vtgen: default and small-frame instances
// compared against a tick-count arithmetic model.
module tb_jtframe_vtgen;

  typedef struct {
    int hce, hbs, hbe, hss, hse;
    int vce, vbs, vbe, vss, vse;
  } tp_t;

  localparam tp_t PD = '{383, 256, 0, 288, 320,
                         263, 240, 16, 250, 253};
  localparam tp_t PS = '{15, 12, 2, 13, 15,
                         11, 9, 2, 9, 11};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pxl_cen = 1'b0;

  logic [8:0] h0, v0, h1, v1;
  logic hi0, vi0, lh0, lv0, hs0, vs0;
  logic hi1, vi1, lh1, lv1, hs1, vs1;

  int total = 0;
  int bad = 0;
  longint n = 0;

  always #5 clk = ~clk;

  jtframe_vtgen dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .H(h0), .V(v0), .Hinit(hi0), .Vinit(vi0),
    .LHBL(lh0), .LVBL(lv0), .HS(hs0), .VS(vs0)
  );

  jtframe_vtgen #(
    .HCNT_END(15), .HB_START(12), .HB_END(2),
    .HS_START(13), .HS_END(15),
    .VCNT_END(11), .VB_START(9), .VB_END(2),
    .VS_START(9), .VS_END(11)
  ) dut_s (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .H(h1), .V(v1), .Hinit(hi1), .Vinit(vi1),
    .LHBL(lh1), .LVBL(lv1), .HS(hs1), .VS(vs1)
  );

  // Position after t pixel ticks, flags straight from the rules
  function automatic logic [23:0] ref_vec(longint t, tp_t p);
    int h, v;
    logic lhbl, lvbl, hs, vs, hin, vin;
    h = int'(t % longint'(p.hce + 1));
    v = int'((t / longint'(p.hce + 1)) % longint'(p.vce + 1));
    lhbl = !(h >= p.hbs || h < p.hbe);
    lvbl = !(v >= p.vbs || v < p.vbe);
    hs = (h >= p.hss) && (h < p.hse);
    vs = (v >= p.vss) && (v < p.vse);
    hin = (h == 0);
    vin = (h == 0) && (v == 0);
    return {h[8:0], v[8:0], hin, vin, lhbl, lvbl, hs, vs};
  endfunction

  task automatic chk(string tag, logic [23:0] obs, logic [23:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic check_both(string tag);
    chk({tag, "/def"}, {h0, v0, hi0, vi0, lh0, lv0, hs0, vs0},
        ref_vec(n, PD));
    chk({tag, "/small"}, {h1, v1, hi1, vi1, lh1, lv1, hs1, vs1},
        ref_vec(n, PS));
  endtask

  task automatic step(logic cen, string tag);
    @(negedge clk);
    pxl_cen = cen;
    @(posedge clk);
    if (cen && !rst) n++;
    #1;
    check_both(tag);
  endtask

  initial begin
    rst = 1'b1;
    pxl_cen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_both("reset");
    chk("reset_lhbl_lvbl", {22'd0, lh0, lv0}, {22'd0, 2'b10});

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), "rand_cen");

    for (int i = 0; i < 4608; i++)
      step(i % 4 == 3, "cen_div4");

    while (n < 46180)
      step(1'b1, "cen_full");
    chk("at_h100_v120", {6'd0, h0, v0}, {6'd0, 9'd100, 9'd120});

    @(negedge clk);
    #2 rst = 1'b1;
    #1 n = 0;
    check_both("async_rst");
    step(1'b1, "rst_hold");
    step(1'b0, "rst_hold");

    @(negedge clk);
    rst = 1'b0;
    step(1'b1, "first_cen");
    chk("first_cen_hv", {6'd0, h0, v0}, {6'd0, 9'd1, 9'd0});

    while (n % 384 != 383)
      step(1'b1, "to_h383");
    for (int i = 0; i < 50; i++)
      step(1'b0, "frozen");
    chk("frozen_hv", {6'd0, h0, v0}, {6'd0, 9'd383, 9'd0});
    step(1'b1, "unfreeze");
    chk("unfreeze_hv", {6'd0, h0, v0}, {6'd0, 9'd0, 9'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_vtgen.md
JTFRAME_VTGEN -- requirements
Module: jtframe_vtgen

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter HCNT_END, 383, last horizontal count; H wraps to 0 after it.
REQ-003 Parameter HB_START, 256, first H value of horizontal blank.
REQ-004 Parameter HB_END, 0, first visible H value; blank when H>=HB_START or H<HB_END.
REQ-005 Parameter HS_START, 288, first H value with HS high.
REQ-006 Parameter HS_END, 320, first H value with HS low again.
REQ-007 Parameter VCNT_END, 263, last vertical count; V wraps to 0 after it.
REQ-008 Parameter VB_START, 240, first V value of vertical blank.
REQ-009 Parameter VB_END, 16, first visible V value; blank when V>=VB_START or V<VB_END.
REQ-010 Parameter VS_START, 250, first V value with VS high.
REQ-011 Parameter VS_END, 253, first V value with VS low again.
REQ-012 clk  in  1  system clock.
REQ-013 rst  in  1  asynchronous active-high reset.
REQ-014 pxl_cen  in  1  pixel clock enable; all state advances only on clk edges with pxl_cen=1.
REQ-015 H  out  9  horizontal pixel counter.
REQ-016 V  out  9  vertical line counter.
REQ-017 Hinit  out  1  high while H==0.
REQ-018 Vinit  out  1  high while H==0 and V==0.
REQ-019 LHBL  out  1  active-low horizontal blank, feeds the blanking stage.
REQ-020 LVBL  out  1  active-low vertical blank, feeds the blanking stage.
REQ-021 HS  out  1  active-high horizontal sync.
REQ-022 VS  out  1  active-high vertical sync.

Function
REQ-023 On pxl_cen: H SHALL become 0 if H==HCNT_END, else H+1.
REQ-024 On pxl_cen with H==HCNT_END: V SHALL become 0 if V==VCNT_END, else V+1; otherwise V holds.
REQ-025 All outputs SHALL be registered; every flag SHALL be decoded from the next H/V values, so flags and counters change on the same clk edge with zero relative skew.
REQ-026 LHBL SHALL be 0 iff H>=HB_START or H<HB_END; HB_END=0 SHALL mean no blank at the line start.
REQ-027 LVBL SHALL be 0 iff V>=VB_START or V<VB_END.
REQ-028 HS SHALL be 1 iff HS_START<=H<HS_END; VS SHALL be 1 iff VS_START<=V<VS_END, so VS changes only at line wrap.
REQ-029 With pxl_cen=0, every output SHALL hold its value.
REQ-030 Counter arithmetic SHALL be 9-bit unsigned; all parameters SHALL be <=511, with HB_END<HB_START<=HCNT_END and VB_END<VB_START<=VCNT_END; simulation SHALL flag an error on violation.
REQ-031 Frame wrap (H==HCNT_END, V==VCNT_END, pxl_cen) SHALL give H=0, V=0, Hinit=1, Vinit=1 on the same edge.
REQ-032 Behaviour SHALL not depend on pxl_cen duty cycle; pxl_cen held high every clk SHALL be legal.

Reset
REQ-033 While rst=1: H=0, V=0, Hinit=1, Vinit=1, HS=0, VS=0, LHBL and LVBL equal to the REQ-026/027 decode of H=V=0 (defaults: LHBL=1, LVBL=0).
REQ-034 Assertion of rst mid-line or mid-frame SHALL force the reset values immediately, without waiting for clk.
REQ-035 After release, counting SHALL resume from H=0, V=0 on the first pxl_cen edge.

Verification
REQ-036 Defaults, pxl_cen every 4th clk, run 2 frames -> 384 cen ticks per line, 264 lines per frame, Vinit high once per frame.
REQ-037 Defaults, one line -> LHBL falls on the edge where H becomes 256 and rises where H becomes 0; HS high for H=288..319 (32 ticks).
REQ-038 Defaults, full frame -> LVBL low for V=240..263 and V=0..15 (224 visible lines); VS high for V=250..252 only, changing when H becomes 0.
REQ-039 rst pulsed asynchronously at H=100, V=120 -> outputs take reset values before next clk edge; after release, first pxl_cen gives H=1, V=0.
REQ-040 pxl_cen held low 50 clks at H=383 -> all outputs frozen; next pxl_cen wraps H to 0 and increments V.
REQ-041 Parameter set HB_END=8, HB_START=8 -> simulation error reported at elaboration/start.
